// File: rtl/updown_counter_ctrl.sv
// Parametrised up/down counter with async preset, sync load, programmable upper
// limit, stop-at-bound or auto-wrap modes, a terminal-count pulse and a done level.

module UdcRippleCell (
  input  logic i_bit,
  input  logic i_up,
  input  logic i_carryIn,
  output logic o_sum,
  output logic o_carryOut
);

  // One cell serves both directions: a carry propagates through 1s when
  // incrementing, and a borrow propagates through 0s when decrementing.
  always_comb begin
    o_sum      = i_bit ^ i_carryIn;
    o_carryOut = (i_up ? i_bit : ~i_bit) & i_carryIn;
  end

endmodule

module updown_counter_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_async,
  input  logic [N-1:0] i_init_number,
  input  logic         i_load,
  input  logic         i_en,
  input  logic         i_up,
  input  logic         i_wrap,
  input  logic [N-1:0] i_limit,
  output logic [N-1:0] o_count,
  output logic         o_tc,
  output logic         o_done
);

  logic [N-1:0] r_count;
  logic         r_tc;

  logic [N:0]   w_carry;
  logic [N-1:0] w_stepped;
  logic         w_atBound;
  logic         w_steppedAtBound;
  logic [N-1:0] w_nextCount;
  logic         w_nextTc;

  assign w_carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chain
      UdcRippleCell u_cell (
        .i_bit      (r_count[gi]),
        .i_up       (i_up),
        .i_carryIn  (w_carry[gi]),
        .o_sum      (w_stepped[gi]),
        .o_carryOut (w_carry[gi+1])
      );
    end
  endgenerate

  // Up bound uses >= so a loaded value above the limit is already at bound.
  always_comb begin
    w_atBound        = i_up ? (r_count >= i_limit) : (r_count == '0);
    w_steppedAtBound = i_up ? (w_stepped >= i_limit) : (w_stepped == '0);
  end

  always_comb begin
    w_nextCount = r_count;
    w_nextTc    = 1'b0;
    if (i_load) begin
      w_nextCount = i_init_number;
    end else if (i_en) begin
      if (!w_atBound) begin
        w_nextCount = w_stepped;
        w_nextTc    = w_steppedAtBound;
      end else if (i_wrap) begin
        w_nextCount = i_up ? '0 : i_init_number;
      end
    end
  end

  // Reset presets to the external init value rather than a constant.
  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      r_count <= i_init_number;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_nextCount;
      r_tc    <= w_nextTc;
    end
  end

  assign o_count = r_count;
  assign o_tc    = r_tc;
  assign o_done  = !i_wrap && w_atBound;

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Directed bench for updown_counter_ctrl; expected values are queued per step
// and popped when the DUT output is sampled one time unit after the edge.

module tb_updown_counter_ctrl;

  localparam int N = 8;

  logic         clk;
  logic         rst_async;
  logic [N-1:0] initNumber;
  logic         load;
  logic         en;
  logic         up;
  logic         wrap;
  logic [N-1:0] limit;
  logic [N-1:0] count;
  logic         tc;
  logic         done;

  typedef struct packed {
    logic [N-1:0] count;
    logic         tc;
    logic         done;
  } exp_t;

  exp_t expQ[$];
  int   totalChecks = 0;
  int   passedChecks = 0;

  updown_counter_ctrl #(.N(N)) dut (
    .clk           (clk),
    .rst_async     (rst_async),
    .i_init_number (initNumber),
    .i_load        (load),
    .i_en          (en),
    .i_up          (up),
    .i_wrap        (wrap),
    .i_limit       (limit),
    .o_count       (count),
    .o_tc          (tc),
    .o_done        (done)
  );

  // Free-running 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a stuck run still reports and terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic ld, input logic e, input logic u,
                               input logic w, input logic [N-1:0] ini,
                               input logic [N-1:0] lim);
    load       = ld;
    en         = e;
    up         = u;
    wrap       = w;
    initNumber = ini;
    limit      = lim;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (expQ.size() == 0) begin
      totalChecks++;
      $error("[TB] FAIL %s: scoreboard empty, observed count=%0d", tag, count);
      return;
    end
    e = expQ.pop_front();
    totalChecks++;
    assert (count === e.count) passedChecks++;
    else $error("[TB] FAIL %s.count: observed %0d expected %0d", tag, count, e.count);
    totalChecks++;
    assert (tc === e.tc) passedChecks++;
    else $error("[TB] FAIL %s.tc: observed %b expected %b", tag, tc, e.tc);
    totalChecks++;
    assert (done === e.done) passedChecks++;
    else $error("[TB] FAIL %s.done: observed %b expected %b", tag, done, e.done);
  endtask

  // Queue the expectation, advance one edge, then sample off the edge.
  task automatic expectNext(input string tag, input logic [N-1:0] c,
                            input logic t, input logic d);
    expQ.push_back('{count: c, tc: t, done: d});
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic expectNow(input string tag, input logic [N-1:0] c,
                           input logic t, input logic d);
    expQ.push_back('{count: c, tc: t, done: d});
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst_async = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd5, 8'd0);

    // Scenario 1: async preset then stop-at-zero down count.
    #2 rst_async = 1'b0;
    expectNow("s1_reset", 8'd5, 1'b0, 1'b0);
    @(negedge clk);
    rst_async = 1'b1;
    expectNext("s1_c4", 8'd4, 1'b0, 1'b0);
    expectNext("s1_c3", 8'd3, 1'b0, 1'b0);
    expectNext("s1_c2", 8'd2, 1'b0, 1'b0);
    expectNext("s1_c1", 8'd1, 1'b0, 1'b0);
    expectNext("s1_c0", 8'd0, 1'b1, 1'b1);
    expectNext("s1_hold0", 8'd0, 1'b0, 1'b1);
    expectNext("s1_hold1", 8'd0, 1'b0, 1'b1);

    // Scenario 2: down count with auto-reload.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 8'd0);
    expectNext("s2_load", 8'd3, 1'b0, 1'b0);
    load = 1'b0;
    expectNext("s2_c2", 8'd2, 1'b0, 1'b0);
    expectNext("s2_c1", 8'd1, 1'b0, 1'b0);
    expectNext("s2_c0", 8'd0, 1'b1, 1'b0);
    expectNext("s2_reload", 8'd3, 1'b0, 1'b0);
    expectNext("s2_c2b", 8'd2, 1'b0, 1'b0);
    expectNext("s2_c1b", 8'd1, 1'b0, 1'b0);
    expectNext("s2_c0b", 8'd0, 1'b1, 1'b0);

    // Scenario 3: up count to limit, then out-of-range load.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd4);
    expectNext("s3_load", 8'd0, 1'b0, 1'b0);
    load = 1'b0;
    expectNext("s3_c1", 8'd1, 1'b0, 1'b0);
    expectNext("s3_c2", 8'd2, 1'b0, 1'b0);
    expectNext("s3_c3", 8'd3, 1'b0, 1'b0);
    expectNext("s3_c4", 8'd4, 1'b1, 1'b1);
    expectNext("s3_hold4", 8'd4, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'd9, 8'd4);
    expectNext("s3_load9", 8'd9, 1'b0, 1'b1);
    load = 1'b0;
    expectNext("s3_hold9", 8'd9, 1'b0, 1'b1);

    // Scenario 4: up wrap across the top of range, then zero-init down wrap.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'd254, 8'd255);
    expectNext("s4_load", 8'd254, 1'b0, 1'b0);
    load = 1'b0;
    expectNext("s4_c255", 8'd255, 1'b1, 1'b0);
    expectNext("s4_wrap0", 8'd0, 1'b0, 1'b0);
    expectNext("s4_c1", 8'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 8'd255);
    expectNext("s4_zload", 8'd0, 1'b0, 1'b0);
    load = 1'b0;
    expectNext("s4_zstay0", 8'd0, 1'b0, 1'b0);
    expectNext("s4_zstay1", 8'd0, 1'b0, 1'b0);

    // Scenario 5: enable hold and load-over-enable priority.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd10, 8'd0);
    expectNext("s5_load", 8'd10, 1'b0, 1'b0);
    load = 1'b0;
    expectNext("s5_c9", 8'd9, 1'b0, 1'b0);
    expectNext("s5_c8", 8'd8, 1'b0, 1'b0);
    expectNext("s5_c7", 8'd7, 1'b0, 1'b0);
    en = 1'b0;
    expectNext("s5_hold_a", 8'd7, 1'b0, 1'b0);
    expectNext("s5_hold_b", 8'd7, 1'b0, 1'b0);
    expectNext("s5_hold_c", 8'd7, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd20, 8'd0);
    expectNext("s5_load20", 8'd20, 1'b0, 1'b0);
    load = 1'b0;
    expectNext("s5_c19", 8'd19, 1'b0, 1'b0);

    // Scenario 6: asynchronous reset between edges mid-count.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd4, 8'd0);
    expectNext("s6_load", 8'd4, 1'b0, 1'b0);
    load = 1'b0;
    expectNext("s6_c3", 8'd3, 1'b0, 1'b0);
    expectNext("s6_c2", 8'd2, 1'b0, 1'b0);
    #2 rst_async = 1'b0;
    expectNow("s6_async", 8'd4, 1'b0, 1'b0);
    expectNext("s6_inreset", 8'd4, 1'b0, 1'b0);
    @(negedge clk);
    rst_async = 1'b1;
    expectNext("s6_resume", 8'd3, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule

// File: doc/updown_counter_ctrl.md
# updown_counter_ctrl

Parametrised successor to the team's down-counter. It is an N-bit up/down counter with asynchronous reset-to-preset, synchronous load, count enable, selectable direction, and stop-at-bound or auto-wrap mode. It adds a programmable upper limit, a one-cycle terminal-count pulse and a done level. It sits in the timer/sequencing datapath and drives countdown displays, delay generators and event timers.

## Interface
- N, default 8: counter width in bits (N ≥ 2).
- clk  in  1  rising-edge clock.
- rst_async  in  1  reset, asynchronous, active-low.
- init_number  in  N  preset value, loaded on reset and on load.
- load  in  1  synchronous load of init_number; highest synchronous priority.
- en  in  1  count enable; the counter holds when low.
- up  in  1  direction: 1 = increment, 0 = decrement.
- wrap  in  1  mode: 1 = auto-wrap/reload, 0 = stop at bound.
- limit  in  N  upper bound for up counting.
- count  out  N  current count, registered.
- tc  out  1  terminal-count pulse, registered, one cycle wide.
- done  out  1  level, combinational from the registers: (wrap==0) && at_bound.

## Operation
- Bound definition:
  - Down (up=0): bound is 0, and at_bound = (count==0).
  - Up (up=1): bound is limit, and at_bound = (count >= limit), so an out-of-range loaded value counts as at bound.
- Step arithmetic:
  - ±1 modulo 2^N, built as a ripple borrow/carry chain of N single-bit cells.
  - No 2^N overflow can occur inside the counting range, because the bound check precedes the step.
- Per-edge priority, evaluated in order:
  1. load=1: count <= init_number; tc <= 0.
  2. en=0: count holds; tc <= 0.
  3. en=1 and !at_bound: count <= count ∓ 1.
  4. en=1, at_bound, wrap=0: count holds at its value.
  5. en=1, at_bound, wrap=1, down: count <= init_number (auto-reload).
  6. en=1, at_bound, wrap=1, up: count <= 0.
- tc rule:
  - tc <= 1 only on an edge taken via case 3 whose next count is at bound (count enters bound through a step).
  - In every other case tc <= 0.
  - A load or reload that lands on the bound never pulses tc.
  - With init_number==0 in down-wrap mode, count stays 0 and tc never fires.
- up, wrap and limit may change on any cycle; they are sampled at the next edge with no internal pipelining.
- done is 0 whenever wrap=1.

## Timing
- Reset, asynchronous, any time: count = init_number and tc = 0 immediately, with no clock needed. done follows combinationally.
- Reset release: the first active edge is the first clk rising edge with rst_async=1. There is no synchronizer inside the block; the parent provides release synchronisation.
- Latency:
  - count updates 1 cycle after a sampled load or en.
  - tc is high in the same cycle that count first shows the bound value, and low the next cycle.
- In wrap mode with en held high, the bound value is visible for exactly one cycle before wrap or reload.
- A direction change while at_bound is evaluated against the new bound on the next edge.
- Sustained clock rate is one step per cycle. The critical path is the N-bit ripple chain plus the bound compare.

## Test plan
All scenarios use N=8.
1. rst_async low with init=5, then release; up=0, wrap=0, en=1:
   - count 5,4,3,2,1,0,0,0.
   - tc=1 only in the first cycle count=0.
   - done=1 from count=0 onward.
2. init=3, up=0, wrap=1, en=1:
   - count 3,2,1,0,3,2,1,0.
   - tc=1 in each cycle count=0; done stays 0.
3. load init=0, then up=1, limit=4, wrap=0:
   - count 0,1,2,3,4,4; tc pulses once at 4; done=1.
   - Then load init=9 with limit=4: count=9 holds, done=1, tc=0.
4. Up wrap across the top of range:
   - up=1, wrap=1, limit=255, load init=254: count 254,255,0,1; tc=1 at 255.
   - Separately, init=0 with up=0, wrap=1: count stays 0 and tc stays 0.
5. Load/enable priority, mid-count:
   - At count=7, drop en for 3 cycles: count holds at 7.
   - Assert load and en together with init=20: next count=20, tc=0.
6. Asynchronous reset mid-operation:
   - At count=2, pulse rst_async low between clock edges: count=init_number immediately and tc=0.
   - Counting resumes from init on the first edge after release.
